// File: rtl/inst_ram_ctrl_pkg.sv
// Shared sizing and boot-state encoding for the instruction RAM controller and its loader.
package inst_ram_ctrl_pkg;

  localparam int unsigned INST_DEPTH = 1024;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned ADDR_W     = $clog2(INST_DEPTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StDrain = 2'd2,
    StRun   = 2'd3
  } state_e;

endpackage

// File: rtl/inst_ram_ctrl_ld_ptr.sv
// Loader auto-increment pointer with sticky wrap flag and saturating write counter.
module inst_ld_ptr #(
  parameter int unsigned INST_DEPTH = 1024,
  parameter int unsigned ADDR_W     = $clog2(INST_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              auto,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap,
  output logic [ADDR_W:0]   count
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W:0]   count_q, count_d;

  always_comb begin
    ptr_d   = ptr_q;
    wrap_d  = wrap_q;
    count_d = count_q;
    // Only auto writes move the pointer; explicit writes still count.
    if (wr && auto) begin
      if (ptr_q == ADDR_W'(INST_DEPTH - 1)) begin
        ptr_d  = '0;
        wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end
    if (wr && (count_q != (ADDR_W + 1)'(INST_DEPTH))) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      count_q <= count_d;
    end
  end

  assign ptr   = ptr_q;
  assign wrap  = wrap_q;
  assign count = count_q;

endmodule

// File: rtl/inst_ram_ctrl.sv
// Instruction BRAM sequencer: boot-time image load, then fetch with loader pre-emption.
module inst_ram_ctrl #(
  parameter int unsigned INST_DEPTH = inst_ram_ctrl_pkg::INST_DEPTH,
  parameter int unsigned INST_WIDTH = inst_ram_ctrl_pkg::INST_WIDTH,
  parameter int unsigned ADDR_W     = $clog2(INST_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_load,
  input  logic                  ld_req,
  input  logic                  ld_auto,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [INST_WIDTH-1:0] ld_data,
  input  logic                  ld_done,
  output logic                  ld_gnt,
  output logic                  ld_wrap,
  output logic [ADDR_W:0]       ld_count,
  input  logic                  fetch_req,
  input  logic [ADDR_W-1:0]     fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [INST_WIDTH-1:0] fetch_rdata,
  output logic                  core_hold,
  output logic [ADDR_W-1:0]     ram_addra,
  output logic [INST_WIDTH-1:0] ram_dina,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic                  ram_rsta,
  input  logic [INST_WIDTH-1:0] ram_douta
);

  import inst_ram_ctrl_pkg::*;

  state_e            state_q, state_d;
  logic              fetch_rvalid_q;
  logic [ADDR_W-1:0] ptr;

  inst_ld_ptr #(
    .INST_DEPTH (INST_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ld_ptr (
    .clk   (clk),
    .rst   (rst),
    .wr    (ld_gnt),
    .auto  (ld_auto),
    .ptr   (ptr),
    .wrap  (ld_wrap),
    .count (ld_count)
  );

  always_comb begin
    state_d   = state_q;
    ld_gnt    = 1'b0;
    fetch_gnt = 1'b0;
    ram_rsta  = 1'b0;
    core_hold = 1'b1;
    case (state_q)
      StIdle: begin
        // Clear the BRAM output register so no stale word is seen after reset.
        ram_rsta = 1'b1;
        state_d  = boot_load ? StLoad : StRun;
      end
      StLoad: begin
        ld_gnt = ld_req;
        if (ld_done) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StRun;
      end
      StRun: begin
        core_hold = 1'b0;
        // Loader wins; the core re-presents its request next cycle.
        ld_gnt    = ld_req;
        fetch_gnt = fetch_req & ~ld_req;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ram_ena   = ld_gnt | fetch_gnt;
    ram_wea   = ld_gnt;
    ram_dina  = ld_data;
    ram_addra = fetch_addr;
    if (ld_gnt) begin
      ram_addra = ld_auto ? ptr : ld_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      fetch_rvalid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_rvalid_q <= fetch_gnt;
    end
  end

  assign fetch_rvalid = fetch_rvalid_q;
  assign fetch_rdata  = ram_douta;

  a_one_grant: assert property (@(posedge clk) disable iff (rst) !(ld_gnt && fetch_gnt));
  a_wea_gnt:   assert property (@(posedge clk) disable iff (rst) ram_wea |-> ld_gnt);

endmodule

// File: tb/tb_inst_ram_ctrl.sv
// Randomised bench for inst_ram_ctrl against a behavioural memory/loader model.
module tb_inst_ram_ctrl;
  import inst_ram_ctrl_pkg::*;

  localparam int DEPTH = INST_DEPTH;
  localparam int AW    = ADDR_W;
  localparam int W     = INST_WIDTH;

  logic          clk, rst, boot_load;
  logic          ld_req, ld_auto, ld_done, ld_gnt, ld_wrap;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic [AW:0]   ld_count;
  logic          fetch_req, fetch_gnt, fetch_rvalid;
  logic [AW-1:0] fetch_addr;
  logic [W-1:0]  fetch_rdata;
  logic          core_hold;
  logic [AW-1:0] ram_addra;
  logic [W-1:0]  ram_dina, ram_douta;
  logic          ram_ena, ram_wea, ram_rsta;

  int vec, miss;

  logic [W-1:0] tb_mem  [DEPTH];
  logic [W-1:0] exp_mem [DEPTH];
  int           exp_ptr, exp_count;
  bit           exp_wrap, exp_rvalid;
  logic [W-1:0] exp_rdata;

  inst_ram_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .boot_load    (boot_load),
    .ld_req       (ld_req),
    .ld_auto      (ld_auto),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_done      (ld_done),
    .ld_gnt       (ld_gnt),
    .ld_wrap      (ld_wrap),
    .ld_count     (ld_count),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .core_hold    (core_hold),
    .ram_addra    (ram_addra),
    .ram_dina     (ram_dina),
    .ram_ena      (ram_ena),
    .ram_wea      (ram_wea),
    .ram_rsta     (ram_rsta),
    .ram_douta    (ram_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM: write-only cycles leave douta untouched.
  always @(posedge clk) begin
    if (ram_rsta) ram_douta <= '0;
    else if (ram_ena) begin
      if (ram_wea) tb_mem[ram_addra] <= ram_dina;
      else ram_douta <= tb_mem[ram_addra];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic drive(input logic lr, input logic la, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic dn, input logic fr,
                       input logic [AW-1:0] fa);
    ld_req = lr; ld_auto = la; ld_addr = a; ld_data = d;
    ld_done = dn; fetch_req = fr; fetch_addr = fa;
  endtask

  // Apply this cycle's expected effects to the model, then move to the next negedge.
  task automatic advance(input bit wr, input bit rd);
    int a;
    if (wr) begin
      a = ld_auto ? exp_ptr : int'(ld_addr);
      exp_mem[a] = ld_data;
      if (ld_auto) begin
        exp_ptr = (exp_ptr + 1) % DEPTH;
        if (exp_ptr == 0) exp_wrap = 1'b1;
      end
      if (exp_count < DEPTH) exp_count++;
    end
    exp_rvalid = rd;
    if (rd) exp_rdata = exp_mem[fetch_addr];
    @(negedge clk);
  endtask

  task automatic do_reset(input logic bl);
    drive(0, 0, '0, '0, 0, 0, '0);
    boot_load = bl;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ptr = 0; exp_count = 0; exp_wrap = 0; exp_rvalid = 0;
  endtask

  task automatic test_reset();
    drive(1, 1, '0, '0, 0, 1, '0);
    @(negedge clk); #3;
    rst = 1'b1; #1;
    vec++; if (core_hold !== 1'b1) begin miss++; $display("FAIL rst_hold got %b want 1", core_hold); end
    vec++; if (ld_count !== '0) begin miss++; $display("FAIL rst_count got %0d want 0", ld_count); end
    vec++; if (ld_wrap !== 1'b0) begin miss++; $display("FAIL rst_wrap got %b want 0", ld_wrap); end
    vec++; if (fetch_rvalid !== 1'b0) begin miss++; $display("FAIL rst_rvalid got %b want 0", fetch_rvalid); end
    vec++; if (ram_ena !== 1'b0) begin miss++; $display("FAIL rst_ena got %b want 0", ram_ena); end
  endtask

  task automatic test_boot_load();
    do_reset(1);
    drive(1, 1, '0, '0, 0, 1, '0); #1;
    vec++; if (ram_rsta !== 1'b1) begin miss++; $display("FAIL boot_rsta got %b want 1", ram_rsta); end
    vec++; if (ram_ena !== 1'b0) begin miss++; $display("FAIL boot_idle_ena got %b want 0", ram_ena); end
    advance(0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, AW'($urandom), W'(32'hA0 + i), 0, 1, AW'($urandom)); #1;
      vec++; if ({ld_gnt, fetch_gnt, ram_wea, core_hold} !== 4'b1011) begin
        miss++; $display("FAIL boot_wr_ctl got %b want 1011", {ld_gnt, fetch_gnt, ram_wea, core_hold}); end
      vec++; if (ram_addra !== AW'(i)) begin miss++; $display("FAIL boot_wr_addr got %0d want %0d", ram_addra, i); end
      advance(1, 0);
    end
    drive(0, 0, '0, '0, 1, 0, '0); #1;
    vec++; if (core_hold !== 1'b1) begin miss++; $display("FAIL boot_done_hold got %b want 1", core_hold); end
    advance(0, 0);
    drive(1, 1, '0, 32'hDEAD, 0, 1, '0); #1;
    vec++; if ({core_hold, ram_ena} !== 2'b10) begin miss++; $display("FAIL boot_drain got %b want 10", {core_hold, ram_ena}); end
    advance(0, 0);
    drive(0, 0, '0, '0, 0, 1, AW'(2)); #1;
    vec++; if (core_hold !== 1'b0) begin miss++; $display("FAIL boot_run_hold got %b want 0", core_hold); end
    vec++; if (ld_count !== (AW + 1)'(4)) begin miss++; $display("FAIL boot_count got %0d want 4", ld_count); end
    vec++; if ({fetch_gnt, ram_wea} !== 2'b10 || ram_addra !== AW'(2)) begin
      miss++; $display("FAIL boot_fetch got %b/%0d want 10/2", {fetch_gnt, ram_wea}, ram_addra); end
    advance(0, 1);
    drive(0, 0, '0, '0, 0, 0, '0); #1;
    vec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'hA2) begin
      miss++; $display("FAIL boot_rdata got %b/%h want 1/a2", fetch_rvalid, fetch_rdata); end
  endtask

  task automatic test_stream();
    do_reset(0); #1;
    vec++; if ({ram_rsta, core_hold} !== 2'b11) begin miss++; $display("FAIL strm_idle got %b want 11", {ram_rsta, core_hold}); end
    advance(0, 0); #1;
    vec++; if (core_hold !== 1'b0) begin miss++; $display("FAIL strm_run got %b want 0", core_hold); end
    vec++; if (fetch_rdata !== '0) begin miss++; $display("FAIL strm_cleared got %h want 0", fetch_rdata); end
    for (int i = 0; i <= 8; i++) begin
      drive(0, 0, '0, '0, 0, i < 8, AW'(i)); #1;
      if (i < 8) begin
        vec++; if (fetch_gnt !== 1'b1) begin miss++; $display("FAIL strm_gnt%0d got %b want 1", i, fetch_gnt); end
      end
      if (i > 0) begin
        vec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== exp_rdata) begin
          miss++; $display("FAIL strm_data%0d got %b/%h want 1/%h", i, fetch_rvalid, fetch_rdata, exp_rdata); end
      end
      advance(0, i < 8);
    end
    vec++; if (fetch_rvalid !== 1'b0) begin miss++; $display("FAIL strm_end got %b want 0", fetch_rvalid); end
  endtask

  task automatic test_preempt();
    logic [W-1:0] old;
    drive(1, 0, AW'(5), 32'h1234, 0, 1, AW'(5)); #1;
    vec++; if ({ld_gnt, fetch_gnt, ram_wea} !== 3'b101 || ram_addra !== AW'(5)) begin
      miss++; $display("FAIL pre_arb got %b/%0d want 101/5", {ld_gnt, fetch_gnt, ram_wea}, ram_addra); end
    advance(1, 0);
    drive(0, 0, '0, '0, 0, 1, AW'(5)); #1;
    vec++; if ({fetch_rvalid, fetch_gnt} !== 2'b01) begin miss++; $display("FAIL pre_retry got %b want 01", {fetch_rvalid, fetch_gnt}); end
    advance(0, 1);
    drive(0, 0, '0, '0, 0, 1, AW'(3)); #1;
    vec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h1234) begin
      miss++; $display("FAIL pre_data got %b/%h want 1/1234", fetch_rvalid, fetch_rdata); end
    advance(0, 1);
    old = exp_rdata;
    drive(1, 0, AW'(3), W'($urandom), 0, 1, AW'(3)); #1;
    vec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== old) begin
      miss++; $display("FAIL pre_hold1 got %b/%h want 1/%h", fetch_rvalid, fetch_rdata, old); end
    advance(1, 0);
    drive(0, 0, '0, '0, 0, 0, '0); #1;
    vec++; if (fetch_rdata !== old) begin miss++; $display("FAIL pre_hold2 got %h want %h", fetch_rdata, old); end
  endtask

  task automatic test_random();
    logic lr, la, fr, dn;
    logic [AW-1:0] a, fa, ea;
    for (int n = 0; n < 300; n++) begin
      lr = ($urandom_range(3) == 0); la = $urandom_range(1) != 0;
      fr = ($urandom_range(3) != 0); dn = ($urandom_range(7) == 0);
      a = AW'($urandom); fa = AW'($urandom);
      drive(lr, la, a, W'($urandom), dn, fr, fa); #1;
      ea = lr ? (la ? AW'(exp_ptr) : a) : fa;
      vec++; if ({ld_gnt, fetch_gnt, ram_wea, ram_ena, core_hold} !== {lr, fr & ~lr, lr, lr | fr, 1'b0}) begin
        miss++; $display("FAIL rnd_ctl%0d got %b want %b", n, {ld_gnt, fetch_gnt, ram_wea, ram_ena, core_hold},
                         {lr, fr & ~lr, lr, lr | fr, 1'b0}); end
      if (lr | fr) begin
        vec++; if (ram_addra !== ea) begin miss++; $display("FAIL rnd_addr%0d got %0d want %0d", n, ram_addra, ea); end
      end
      vec++; if (fetch_rvalid !== exp_rvalid || (exp_rvalid && fetch_rdata !== exp_rdata)) begin
        miss++; $display("FAIL rnd_rd%0d got %b/%h want %b/%h", n, fetch_rvalid, fetch_rdata, exp_rvalid, exp_rdata); end
      vec++; if (ld_count !== (AW + 1)'(exp_count) || ld_wrap !== exp_wrap) begin
        miss++; $display("FAIL rnd_cnt%0d got %0d/%b want %0d/%b", n, ld_count, ld_wrap, exp_count, exp_wrap); end
      advance(lr, fr & ~lr);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] last;
    do_reset(1);
    advance(0, 0);
    for (int i = 0; i <= DEPTH; i++) begin
      last = W'($urandom);
      drive(1, 1, AW'($urandom), last, 0, 0, '0); #1;
      vec++; if (ram_addra !== AW'(exp_ptr) || ld_wrap !== exp_wrap) begin
        miss++; $display("FAIL wrap_w%0d got %0d/%b want %0d/%b", i, ram_addra, ld_wrap, exp_ptr, exp_wrap); end
      advance(1, 0);
    end
    drive(0, 0, '0, '0, 0, 0, '0); #1;
    vec++; if (ld_wrap !== 1'b1 || ld_count !== (AW + 1)'(1024)) begin
      miss++; $display("FAIL wrap_sat got %b/%0d want 1/1024", ld_wrap, ld_count); end
    drive(0, 1, '0, '0, 1, 0, '0); #1;
    vec++; if (ram_ena !== 1'b0) begin miss++; $display("FAIL wrap_done got %b want 0", ram_ena); end
    advance(0, 0);
    advance(0, 0);
    drive(1, 1, '0, W'($urandom), 0, 0, '0); #1;
    vec++; if (ram_addra !== AW'(1)) begin miss++; $display("FAIL wrap_ptr got %0d want 1", ram_addra); end
    advance(1, 0);
    drive(0, 0, '0, '0, 0, 1, '0); #1;
    advance(0, 1);
    vec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== last) begin
      miss++; $display("FAIL wrap_last got %b/%h want 1/%h", fetch_rvalid, fetch_rdata, last); end
    vec++; if (ld_count !== (AW + 1)'(1024)) begin miss++; $display("FAIL wrap_cnt got %0d want 1024", ld_count); end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    advance(0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, '0, W'($urandom), 0, 0, '0);
      advance(1, 0);
    end
    drive(1, 1, '0, W'($urandom), 0, 0, '0); #1;
    vec++; if (ld_gnt !== 1'b1) begin miss++; $display("FAIL ar_pre got %b want 1", ld_gnt); end
    #2 rst = 1'b1; #1;
    vec++; if ({core_hold, ram_ena, ld_gnt} !== 3'b100 || ld_count !== '0) begin
      miss++; $display("FAIL ar_now got %b/%0d want 100/0", {core_hold, ram_ena, ld_gnt}, ld_count); end
    @(negedge clk);
    rst = 1'b0;
    exp_ptr = 0; exp_count = 0; exp_wrap = 0; exp_rvalid = 0;
    drive(0, 0, '0, '0, 0, 0, '0); #1;
    vec++; if ({ram_rsta, core_hold} !== 2'b11) begin miss++; $display("FAIL ar_idle got %b want 11", {ram_rsta, core_hold}); end
    advance(0, 0);
  endtask

  task automatic test_done_same_cycle();
    logic [W-1:0] d;
    d = W'($urandom);
    drive(1, 0, AW'(9), d, 1, 0, '0); #1;
    vec++; if ({ld_gnt, ram_wea, core_hold} !== 3'b111) begin
      miss++; $display("FAIL same_wr got %b want 111", {ld_gnt, ram_wea, core_hold}); end
    advance(1, 0);
    drive(1, 1, '0, W'($urandom), 0, 1, AW'(4)); #1;
    vec++; if ({core_hold, ram_ena} !== 2'b10) begin miss++; $display("FAIL same_drain got %b want 10", {core_hold, ram_ena}); end
    advance(0, 0);
    drive(0, 0, '0, '0, 1, 1, AW'(9)); #1;
    vec++; if ({core_hold, fetch_gnt} !== 2'b01) begin miss++; $display("FAIL same_run got %b want 01", {core_hold, fetch_gnt}); end
    advance(0, 1);
    drive(0, 0, '0, '0, 1, 0, '0); #1;
    vec++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== d) begin
      miss++; $display("FAIL same_data got %b/%h want 1/%h", fetch_rvalid, fetch_rdata, d); end
    vec++; if (ld_count !== (AW + 1)'(exp_count)) begin miss++; $display("FAIL same_cnt got %0d want %0d", ld_count, exp_count); end
    advance(0, 0);
    vec++; if (core_hold !== 1'b0) begin miss++; $display("FAIL same_ignore got %b want 0", core_hold); end
  endtask

  initial begin
    vec = 0; miss = 0;
    rst = 1'b1; boot_load = 1'b0;
    drive(0, 0, '0, '0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = W'($urandom);
      exp_mem[i] = tb_mem[i];
    end
    exp_ptr = 0; exp_count = 0; exp_wrap = 0; exp_rvalid = 0; exp_rdata = '0;
    test_reset();
    test_boot_load();
    test_stream();
    test_preempt();
    test_random();
    test_wrap();
    test_async_reset();
    test_done_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/inst_ram_ctrl.md
Name: inst_ram_ctrl

Overview:
- Sequences the single-port instruction BRAM and shares it between two requesters: the core fetch unit (read-only) and the program loader (write, UART/debug).
- Owns the boot flow: holds the core in reset while the image loads, then releases it.
- Allows runtime instruction patching by letting the loader pre-empt fetch.
- Sits between the core fetch stage, the loader, and the instruction BRAM.

Parameters:
- INST_DEPTH, 1024, number of instruction words in the BRAM.
- INST_WIDTH, 32, instruction word width in bits.
- ADDR_W, $clog2(INST_DEPTH), word address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- boot_load  in  1  strap, sampled in IDLE: 1 = enter LOAD, 0 = go straight to RUN.
- ld_req  in  1  loader write request.
- ld_auto  in  1  1 = write at internal pointer, 0 = write at ld_addr.
- ld_addr  in  ADDR_W  explicit write address.
- ld_data  in  INST_WIDTH  write data.
- ld_done  in  1  loader end-of-image pulse.
- ld_gnt  out  1  write performed this cycle.
- ld_wrap  out  1  sticky: auto pointer wrapped.
- ld_count  out  ADDR_W+1  words written since reset, saturating.
- fetch_req  in  1  core read request.
- fetch_addr  in  ADDR_W  read word address.
- fetch_gnt  out  1  read issued this cycle.
- fetch_rvalid  out  1  fetch_rdata valid.
- fetch_rdata  out  INST_WIDTH  read data.
- core_hold  out  1  keeps the core in reset/stall.
- ram_addra  out  ADDR_W  BRAM address.
- ram_dina  out  INST_WIDTH  BRAM write data.
- ram_ena  out  1  BRAM enable.
- ram_wea  out  1  BRAM write enable.
- ram_rsta  out  1  BRAM output-register reset.
- ram_douta  in  INST_WIDTH  BRAM read data.

Behaviour:
- Reset values (async on rst): state=IDLE, auto pointer=0, ld_count=0, ld_wrap=0, fetch_rvalid=0, core_hold=1.
- All other outputs are combinational decodes of state and requests. fetch_rdata = ram_douta (pass-through).

State machine:
- IDLE: ram_rsta=1 for one cycle (clears douta), no grants. Next state: LOAD if boot_load, else RUN.
- LOAD: core_hold=1, fetch_gnt=0. ld_req gives ld_gnt=1, ram_ena=1, ram_wea=1 in the same cycle. ld_done moves to DRAIN.
- If ld_req and ld_done arrive in the same cycle, the write is performed first and then the FSM moves to DRAIN.
- DRAIN: one cycle, no grants, core_hold=1. Next state: RUN.
- RUN: core_hold=0. Fixed priority: loader over fetch.
  - ld_req wins: fetch_gnt=0 and the core must re-present the same request.
  - Otherwise fetch_req gives fetch_gnt=1, ram_ena=1, ram_wea=0, ram_addra=fetch_addr.
- ld_done in RUN is ignored.

Read latency and data hold:
- fetch_rvalid is registered: it equals the previous cycle's fetch_gnt. Read latency is exactly 1 cycle.
- A write cycle does not disturb ram_douta, so rdata from the prior read stays valid while the loader pre-empts.

Write addressing:
- ram_addra = ld_auto ? ptr : ld_addr; ram_dina = ld_data.
- On an auto write, ptr increments. At INST_DEPTH-1 it wraps to 0 and sets ld_wrap (sticky until rst).
- Explicit writes do not move ptr.
- ld_count increments on every ld_gnt and saturates at INST_DEPTH.

Invariants and reset:
- ram_ena=0 whenever nothing is granted.
- At most one grant per cycle; ram_wea=1 only together with ld_gnt.
- Reset mid-LOAD or mid-RUN: everything returns to IDLE immediately. A write in flight is not guaranteed; BRAM contents are retained.

Decomposition:
- Shared package/defines: INST_DEPTH, INST_WIDTH, and the state encoding constants IDLE/LOAD/DRAIN/RUN, reused by the debug/loader block.
- One natural sub-module, inst_ld_ptr: the auto-increment pointer, wrap flag and saturating counter.
- FSM and arbitration stay in the top module.

Test Plan:
- Boot with boot_load=1; after reset, 4 auto writes 0xA0..0xA3, then ld_done -> ram writes addr 0..3, ld_count=4; core_hold falls exactly 2 cycles after ld_done (DRAIN, then RUN); then fetch addr 2 -> fetch_rvalid one cycle later with rdata=0xA2.
- boot_load=0 -> RUN reached 1 cycle after reset release; fetch_req every cycle for addr 0..7 -> gnt each cycle, rvalid continuous, no bubbles.
- RUN, fetch_req and ld_req in the same cycle (explicit addr 5, data 0x1234) -> ld_gnt=1, fetch_gnt=0, rvalid=0 next cycle; fetch retried gets the grant; fetch addr 5 returns 0x1234.
- Auto writes of INST_DEPTH+1 words -> ld_wrap sets at word INST_DEPTH, ptr=1, ld_count saturates at 1024, addr 0 holds the last word.
- Assert rst asynchronously mid-LOAD (between clock edges) -> core_hold=1, ld_count=0 and ram_ena=0 immediately; after release, the FSM passes through IDLE with ram_rsta=1.
- ld_req and ld_done in the same LOAD cycle -> the write lands, then DRAIN; an ld_done pulse in RUN changes nothing.
